// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, frame geometry and char placement helper for the LCD frame arbiter
package lcd_pkg;
    typedef enum logic [1:0] {IDLE, OWN, HOLD} state_t;
    localparam int CHAR_W  = 8;
    localparam int N_CHARS = 32;
    localparam int ADDR_W  = 5;
    localparam int FRAME_W = 257;
    localparam logic [CHAR_W-1:0] SPACE = 8'h20;
    function automatic int char_lsb(input int k);
        return 248 - CHAR_W * k;
    endfunction
endpackage

// File: rtl/lcd_frame_arbiter_if.sv
// lcd_frame_arbiter_if: requester-side bus and LCD frame outputs of the arbiter
interface lcd_frame_arbiter_if #(parameter int N_REQ = 3);
    import lcd_pkg::*;
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        wr_en;
    logic [ADDR_W*N_REQ-1:0] wr_addr;
    logic [CHAR_W*N_REQ-1:0] wr_data;
    logic [N_REQ-1:0]        done;
    logic [FRAME_W-1:0]      chars;
    logic                    frame_valid;
    logic                    busy;
    logic                    timeout_err;
    modport master (output req, wr_en, wr_addr, wr_data, done,
                    input gnt, chars, frame_valid, busy, timeout_err);
    modport slave (input req, wr_en, wr_addr, wr_data, done,
                   output gnt, chars, frame_valid, busy, timeout_err);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt
);
    logic [$clog2(N)-1:0] idx;
    logic                 found;
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = $clog2(N)'((int'(ptr) + i) % N);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/lcd_frame_arbiter.sv
// lcd_frame_arbiter: round-robin ownership of a shadowed 2x16 LCD frame with atomic commit and hold
module lcd_frame_arbiter
    import lcd_pkg::*;
#(
    parameter int N_REQ          = 3,
    parameter int HOLD_CYCLES    = 25_000_000,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input logic          clk,
    input logic          rst_n,
    lcd_frame_arbiter_if.slave bus
);
    localparam int PW   = $clog2(N_REQ);
    localparam int MAXC = HOLD_CYCLES > TIMEOUT_CYCLES ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    state_t                      state_q, state_d;
    logic [N_REQ-1:0]            gnt_q, gnt_d, win;
    logic [PW-1:0]               ptr_q, ptr_d, own, own_nxt;
    logic [CW-1:0]               cnt_q, cnt_d, cnt_inc;
    logic [N_CHARS*CHAR_W-1:0]   chars_q, chars_d;
    logic [CHAR_W-1:0]           shadow_q [N_CHARS];
    logic [CHAR_W-1:0]           shadow_d [N_CHARS];
    logic                        frame_valid_q, frame_valid_d;
    logic                        timeout_err_q, timeout_err_d;
    logic [ADDR_W-1:0]           addr_a [N_REQ];
    logic [CHAR_W-1:0]           data_a [N_REQ];

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (bus.req),
        .ptr (ptr_q),
        .en  (state_q == IDLE),
        .gnt (win)
    );

    always_comb begin
        own = '0;
        for (int i = 0; i < N_REQ; i++) begin
            addr_a[i] = bus.wr_addr[i*ADDR_W +: ADDR_W];
            data_a[i] = bus.wr_data[i*CHAR_W +: CHAR_W];
            if (gnt_q[i]) own = PW'(i);
        end
    end

    assign own_nxt = (own == PW'(N_REQ - 1)) ? '0 : own + 1'b1;
    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_inc;
        chars_d       = chars_q;
        shadow_d      = shadow_q;
        frame_valid_d = 1'b0;
        timeout_err_d = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (|win) begin
                gnt_d   = win;
                state_d = OWN;
                for (int k = 0; k < N_CHARS; k++) shadow_d[k] = chars_q[char_lsb(k) +: CHAR_W];
            end
        end else if (state_q == OWN) begin
            if (bus.wr_en[own]) shadow_d[addr_a[own]] = data_a[own];
            if (bus.done[own] || !bus.req[own] || cnt_q == TO_LAST) begin
                gnt_d = '0;
                ptr_d = own_nxt;
                cnt_d = '0;
            end
            // done outranks both abort and timeout, so a late commit is never lost
            if (bus.done[own]) begin
                for (int k = 0; k < N_CHARS; k++) chars_d[char_lsb(k) +: CHAR_W] = shadow_d[k];
                state_d       = HOLD;
                frame_valid_d = 1'b1;
            end else if (!bus.req[own]) begin
                state_d = IDLE;
            end else if (cnt_q == TO_LAST) begin
                state_d       = HOLD;
                timeout_err_d = 1'b1;
            end
        end else begin
            state_d = (cnt_q == HOLD_LAST) ? IDLE : HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            chars_q       <= {N_CHARS{SPACE}};
            shadow_q      <= '{default: SPACE};
            frame_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            chars_q       <= chars_d;
            shadow_q      <= shadow_d;
            frame_valid_q <= frame_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.chars       = {1'b0, chars_q};
    assign bus.frame_valid = frame_valid_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.busy        = state_q != IDLE;
endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// tb_lcd_frame_arbiter: directed vectors and timing sequences for lcd_frame_arbiter
module tb_lcd_frame_arbiter;
    import lcd_pkg::*;

    typedef struct {
        string       name;
        logic [2:0]  req, en, done;
        logic [14:0] addr;
        logic [23:0] data;
        logic [2:0]  exp_gnt;
        logic        exp_busy, exp_fv;
    } vec_t;

    localparam logic [255:0] BLANK = {32{8'h20}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    vec_t vecs [12];

    always #5 clk = ~clk;

    lcd_frame_arbiter_if #(.N_REQ(3)) bus ();

    lcd_frame_arbiter #(.N_REQ(3), .HOLD_CYCLES(20), .TIMEOUT_CYCLES(100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic vec_t mk(string n, logic [2:0] rq, logic [2:0] en, logic [2:0] dn, int s,
                                logic [4:0] a, logic [7:0] d, logic [2:0] eg, logic eb, logic ef);
        vec_t v;
        v.name = n; v.req = rq; v.en = en; v.done = dn;
        v.addr = 15'(a) << (5 * s);
        v.data = 24'(d) << (8 * s);
        v.exp_gnt = eg; v.exp_busy = eb; v.exp_fv = ef;
        return v;
    endfunction

    function automatic logic [255:0] put(logic [255:0] f, int k, logic [7:0] c);
        f[248 - 8*k +: 8] = c;
        return f;
    endfunction

    function automatic logic [255:0] text(string s);
        logic [255:0] f;
        f = BLANK;
        for (int i = 0; i < s.len(); i++) f = put(f, i, s[i]);
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string n, logic [256:0] act, logic [256:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic drive(logic [2:0] rq, logic [2:0] en, logic [2:0] dn, logic [14:0] a, logic [23:0] d);
        bus.req = rq; bus.wr_en = en; bus.done = dn; bus.wr_addr = a; bus.wr_data = d;
    endtask

    task automatic apply(int i);
        drive(vecs[i].req, vecs[i].en, vecs[i].done, vecs[i].addr, vecs[i].data);
        tick();
        chk({vecs[i].name, " gnt"}, bus.gnt, vecs[i].exp_gnt);
        chk({vecs[i].name, " busy"}, bus.busy, vecs[i].exp_busy);
        chk({vecs[i].name, " frame_valid"}, bus.frame_valid, vecs[i].exp_fv);
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.gnt == 3'b000 && n < 200);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, terr_early, terr_cnt;
        int order [4] = '{0, 1, 2, 0};
        vecs[0]  = mk("t1 grant",     3'b010, 3'b000, 3'b000, 1, 5'd0, 8'h00, 3'b010, 1'b1, 1'b0);
        vecs[1]  = mk("t1 H",         3'b010, 3'b010, 3'b000, 1, 5'd0, 8'h48, 3'b010, 1'b1, 1'b0);
        vecs[2]  = mk("t1 E",         3'b010, 3'b010, 3'b000, 1, 5'd1, 8'h45, 3'b010, 1'b1, 1'b0);
        vecs[3]  = mk("t1 L",         3'b010, 3'b010, 3'b000, 1, 5'd2, 8'h4C, 3'b010, 1'b1, 1'b0);
        vecs[4]  = mk("t1 L2",        3'b010, 3'b010, 3'b000, 1, 5'd3, 8'h4C, 3'b010, 1'b1, 1'b0);
        vecs[5]  = mk("t1 O",         3'b010, 3'b010, 3'b000, 1, 5'd4, 8'h4F, 3'b010, 1'b1, 1'b0);
        vecs[6]  = mk("t1 commit",    3'b010, 3'b000, 3'b010, 1, 5'd0, 8'h00, 3'b000, 1'b1, 1'b1);
        vecs[7]  = mk("t1 hold",      3'b000, 3'b000, 3'b000, 1, 5'd0, 8'h00, 3'b000, 1'b1, 1'b0);
        vecs[8]  = mk("t5 non-owner", 3'b111, 3'b010, 3'b010, 1, 5'd0, 8'h58, 3'b001, 1'b1, 1'b0);
        vecs[9]  = mk("t5 owner wr",  3'b111, 3'b001, 3'b000, 0, 5'd0, 8'h51, 3'b001, 1'b1, 1'b0);
        vecs[10] = mk("t5 abort",     3'b110, 3'b001, 3'b000, 0, 5'd1, 8'h52, 3'b000, 1'b0, 1'b0);
        vecs[11] = mk("t5 regrant",   3'b110, 3'b000, 3'b000, 0, 5'd0, 8'h00, 3'b010, 1'b1, 1'b0);

        drive(3'b000, 3'b000, 3'b000, '0, '0);
        tick();
        tick();
        chk("reset gnt", bus.gnt, 3'b000);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset frame_valid", bus.frame_valid, 1'b0);
        chk("reset timeout_err", bus.timeout_err, 1'b0);
        chk("reset chars", bus.chars, {1'b0, BLANK});
        rst_n = 1'b1;

        // HELLO frame and its hold window
        for (int i = 0; i < 8; i++) apply(i);
        chk("t1 chars", bus.chars, {1'b0, text("HELLO")});
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.busy && n < 50);
        chk("t1 hold length", n, 19);

        // line-2 write merged with done keeps line-1 text
        drive(3'b001, 3'b000, 3'b000, '0, '0);
        tick();
        chk("t3 gnt", bus.gnt, 3'b001);
        drive(3'b001, 3'b001, 3'b001, 15'd16, 24'h41);
        tick();
        chk("t3 frame_valid", bus.frame_valid, 1'b1);
        chk("t3 gnt drop", bus.gnt, 3'b000);
        chk("t3 chars", bus.chars, {1'b0, put(text("HELLO"), 16, 8'h41)});
        chk("t3 char16", bus.chars[127:120], 8'h41);
        drive(3'b000, 3'b000, 3'b000, '0, '0);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.busy && n < 50);
        chk("t3 hold length", n, 20);

        // all three requesting: rotation 0,1,2,0 with 20 hold + 1 idle between grants
        drive(3'b111, 3'b000, 3'b000, '0, '0);
        rst_n = 1'b0;
        tick();
        chk("t2 reset chars", bus.chars, {1'b0, BLANK});
        chk("t2 reset gnt", bus.gnt, 3'b000);
        rst_n = 1'b1;
        tick();
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin
                wait_gnt(n);
                chk("t2 gap", n, 21);
            end
            chk("t2 order", bus.gnt, 3'b001 << order[j]);
            drive(3'b111, 3'b000, 3'b001 << order[j], '0, '0);
            tick();
            chk("t2 frame_valid", bus.frame_valid, 1'b1);
            drive(j == 3 ? 3'b101 : 3'b111, 3'b000, 3'b000, '0, '0);
        end

        // owner 2 stalls: revoke after 100 cycles, frame untouched
        wait_gnt(n);
        chk("t4 gap", n, 21);
        chk("t4 gnt", bus.gnt, 3'b100);
        drive(3'b101, 3'b100, 3'b000, 15'd5 << 10, 24'h5A << 16);
        n = 0;
        terr_early = 0;
        do begin
            tick();
            n++;
            drive(3'b101, 3'b000, 3'b000, '0, '0);
            if (bus.gnt != 3'b000) terr_early += int'(bus.timeout_err);
        end while (bus.gnt != 3'b000 && n < 200);
        chk("t4 own length", n, 100);
        chk("t4 timeout_err", bus.timeout_err, 1'b1);
        chk("t4 early timeout_err", terr_early, 0);
        chk("t4 chars", bus.chars, {1'b0, BLANK});
        n = 0;
        terr_cnt = 0;
        do begin
            tick();
            n++;
            terr_cnt += int'(bus.timeout_err);
        end while (bus.gnt == 3'b000 && n < 200);
        chk("t4 hold gap", n, 21);
        chk("t4 next gnt", bus.gnt, 3'b001);
        chk("t4 single pulse", terr_cnt, 0);

        // non-owner ignored, then owner aborts
        for (int i = 8; i < 12; i++) apply(i);
        chk("t5 chars", bus.chars, {1'b0, BLANK});

        // commit a frame, then reset in the middle of the next owner's writes
        drive(3'b110, 3'b010, 3'b000, 15'd0 << 5, 24'h4F << 8);
        tick();
        drive(3'b110, 3'b010, 3'b010, 15'd1 << 5, 24'h4B << 8);
        tick();
        chk("t6 frame_valid", bus.frame_valid, 1'b1);
        chk("t6 chars OK", bus.chars, {1'b0, text("OK")});
        drive(3'b110, 3'b000, 3'b000, '0, '0);
        wait_gnt(n);
        chk("t6 gap", n, 21);
        chk("t6 gnt", bus.gnt, 3'b100);
        for (int i = 0; i < 3; i++) begin
            drive(3'b110, 3'b100, 3'b000, 15'(i) << 10, 24'(8'h61 + i) << 16);
            tick();
        end
        drive(3'b110, 3'b000, 3'b000, '0, '0);
        rst_n = 1'b0;
        tick();
        chk("t6 reset gnt", bus.gnt, 3'b000);
        chk("t6 reset busy", bus.busy, 1'b0);
        chk("t6 reset chars", bus.chars, {1'b0, BLANK});
        chk("t6 reset frame_valid", bus.frame_valid, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("t6 post-reset gnt", bus.gnt, 3'b010);
        drive(3'b110, 3'b000, 3'b010, '0, '0);
        tick();
        chk("t6 empty commit fv", bus.frame_valid, 1'b1);
        chk("t6 empty commit chars", bus.chars, {1'b0, BLANK});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/lcd_frame_arbiter.md
Name: lcd_frame_arbiter

Overview:
- Shares the 2x16 character LCD frame among N requesters (status, menu, error reporting, etc.).
- A round-robin arbiter grants one requester exclusive ownership.
- The owner writes characters into a shadow buffer, then commits it atomically to the 257-bit `chars` bus that feeds the LCD driver.
- After each commit the frame is held for a minimum time so the driver's refresh loop always shows complete, stable messages.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- HOLD_CYCLES, 25_000_000, minimum cycles a committed frame stays displayed before the next grant (0.5 s at 50 MHz).
- TIMEOUT_CYCLES, 50_000_000, maximum ownership cycles without `done` before the grant is revoked.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- req  in  N_REQ  per-requester ownership request, level
- gnt  out  N_REQ  one-hot grant, registered
- wr_en  in  N_REQ  per-requester character write strobe
- wr_addr  in  5*N_REQ  per-requester char index; slice i = [5i+4:5i]; 0-15 line 1, 16-31 line 2
- wr_data  in  8*N_REQ  per-requester ASCII byte; slice i = [8i+7:8i]
- done  in  N_REQ  per-requester commit pulse
- chars  out  257  frame to LCD driver; char k at [255-8k:248-8k]; bit 256 tied 0
- frame_valid  out  1  one-cycle pulse on the cycle after `chars` updates
- busy  out  1  high in OWN or HOLD
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; gnt=0; frame_valid=0; timeout_err=0; busy=0.
  - chars = 32 x 8'h20 (spaces); shadow = spaces.
  - rr pointer = 0; counters = 0.
  - Reset mid-OWN or mid-HOLD discards the shadow and any pending commit.
- States: IDLE, OWN, HOLD.
- IDLE:
  - If any req is set, pick the winner by round-robin, starting at index (last_owner+1) mod N_REQ.
  - Next edge: gnt[winner]=1, state=OWN, shadow<=chars (unwritten positions keep the current text), own_cnt=0.
  - Grant latency is 1 cycle from req sampled.
- OWN:
  - Only the owner's wr_en/wr_addr/wr_data/done are honoured; all other requesters' inputs are ignored.
  - wr_en=1 writes shadow[wr_addr]<=wr_data. Any later write to the same address wins.
  - done=1 (with or without a same-cycle wr_en) at edge t:
    - the same-cycle write is merged first;
    - chars<=merged shadow; gnt<=0; state=HOLD; hold_cnt=0; frame_valid=1 during cycle t+1 only;
    - last_owner<=owner.
  - Owner drops req without done: abort. gnt<=0, shadow discarded, chars unchanged, state=IDLE (no hold), last_owner<=owner.
  - own_cnt reaches TIMEOUT_CYCLES-1 without done:
    - revoke: gnt<=0, shadow discarded, timeout_err pulses 1 cycle, state=HOLD, last_owner<=owner.
    - The HOLD here keeps a misbehaving client from re-grabbing immediately.
  - done and timeout on the same edge: done wins (commit).
- HOLD:
  - gnt=0; requests stay pending; hold_cnt increments.
  - At hold_cnt==HOLD_CYCLES-1, state<=IDLE.
  - HOLD_CYCLES=0 is legal: HOLD lasts exactly 1 cycle.
- busy=1 whenever state is not IDLE.
- Counter widths: $clog2(max(HOLD_CYCLES, TIMEOUT_CYCLES)+1). Counters saturate and never wrap.
- Round-robin pointer wrap: from owner N_REQ-1, the search starts at 0.
- A requester that keeps req high after its commit waits behind every other active requester.
- done from the owner while req is low on the same cycle is treated as a commit.

Decomposition:
- Package lcd_pkg:
  - state enum {IDLE, OWN, HOLD};
  - CHAR_W=8, N_CHARS=32, ADDR_W=5, SPACE=8'h20, FRAME_W=257;
  - function char_lsb(k) = 248-8k.
- Sub-module rr_arbiter:
  - inputs: req vector, pointer, enable; output: one-hot grant.
  - Purely combinational priority rotate; registered by the parent.
- Shadow buffer: 32x8 register array in the parent.

Test Plan (HOLD_CYCLES=20, TIMEOUT_CYCLES=100, N_REQ=3):
1. Reset, then req[1]=1 -> gnt=3'b010 one cycle later. Write "HELLO" at addr 0-4, pulse done -> chars[255:216]="HELLO", rest spaces, frame_valid one pulse, busy high 20 more cycles, then IDLE.
2. req=3'b111 held continuously, each owner commits immediately -> grant order 0,1,2,0. Consecutive grants separated by 20 HOLD cycles plus 1 IDLE cycle.
3. Owner 0 writes addr 16='A' with done in the same cycle -> chars[127:120]=8'h41; the line-1 text from the previous frame is preserved.
4. Owner 2 granted, never asserts done -> after 100 cycles gnt drops, timeout_err pulses once, chars unchanged, 20-cycle HOLD. Pending req[0] is granted next.
5. Non-owner 1 asserts wr_en/done while 0 owns -> no effect. Then owner 0 drops req mid-write -> chars unchanged, no HOLD, gnt to 1 after 1 cycle.
6. rst_n=0 during OWN after 3 writes -> chars all 8'h20, gnt=0, state IDLE next cycle.
